// File: rtl/clock_divider_pkg.sv
// Shared types and default sizing for the clock_divider family of blocks.
package clock_divider_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int PER_W_DEF       = 16;
    localparam int GATE_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        MEASURE = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous input with a rising-edge pulse
// taken from the synchronised output.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic nrst,
    input  logic d,
    output logic q_sync,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_sync = sync_q[SYNC_STAGES-1];
    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clock_divider_monitor.sv
// Gated edge counter and period meter for the divided clock; also flags a
// window with no edges as stuck.
module clock_divider_monitor
    import clock_divider_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int PER_W       = PER_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             nrst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_valid,
    output logic [PER_W-1:0] period_out,
    output logic             period_valid,
    output logic             period_ovf,
    output logic             stuck
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic rise;
    logic sig_sync_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_in (clk_in),
        .nrst   (nrst),
        .d      (sig_in),
        .q_sync (sig_sync_unused),
        .rise   (rise)
    );

    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic [PER_W-1:0]  per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]  count_out_q, count_out_d;
    logic              count_valid_q, count_valid_d;
    logic [PER_W-1:0]  period_out_q, period_out_d;
    logic              period_valid_q, period_valid_d;
    logic              period_ovf_q, period_ovf_d;
    logic              stuck_q, stuck_d;
    logic [CNT_W-1:0]  window_cnt;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        gate_cnt_d     = gate_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        per_cnt_d      = per_cnt_q;
        count_out_d    = count_out_q;
        count_valid_d  = 1'b0;
        period_out_d   = period_out_q;
        period_valid_d = 1'b0;
        period_ovf_d   = period_ovf_q;
        stuck_d        = stuck_q;
        window_cnt     = (rise && edge_cnt_q != '1) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;

        if (!enable) begin
            state_d    = IDLE;
            gate_cnt_d = '0;
            edge_cnt_d = '0;
            per_cnt_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARMING;
                ARMING, MEASURE: begin
                    // A rise in the terminal cycle still belongs to the closing window.
                    if (gate_cnt_q == GATE_LAST) begin
                        gate_cnt_d    = '0;
                        edge_cnt_d    = '0;
                        count_out_d   = window_cnt;
                        count_valid_d = 1'b1;
                        stuck_d       = (window_cnt == '0);
                    end else begin
                        gate_cnt_d = gate_cnt_q + GATE_W'(1);
                        edge_cnt_d = window_cnt;
                    end

                    if (state_q == ARMING) begin
                        if (rise) begin
                            per_cnt_d = PER_W'(1);
                            state_d   = MEASURE;
                        end
                    end else if (rise) begin
                        period_out_d   = per_cnt_q;
                        period_valid_d = 1'b1;
                        period_ovf_d   = (per_cnt_q == '1);
                        per_cnt_d      = PER_W'(1);
                    end else if (per_cnt_q != '1) begin
                        per_cnt_d = per_cnt_q + PER_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge nrst) begin
        if (!nrst) begin
            state_q        <= IDLE;
            gate_cnt_q     <= '0;
            edge_cnt_q     <= '0;
            per_cnt_q      <= '0;
            count_out_q    <= '0;
            count_valid_q  <= 1'b0;
            period_out_q   <= '0;
            period_valid_q <= 1'b0;
            period_ovf_q   <= 1'b0;
            stuck_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            gate_cnt_q     <= gate_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            per_cnt_q      <= per_cnt_d;
            count_out_q    <= count_out_d;
            count_valid_q  <= count_valid_d;
            period_out_q   <= period_out_d;
            period_valid_q <= period_valid_d;
            period_ovf_q   <= period_ovf_d;
            stuck_q        <= stuck_d;
        end
    end

    assign count_out    = count_out_q;
    assign count_valid  = count_valid_q;
    assign period_out   = period_out_q;
    assign period_valid = period_valid_q;
    assign period_ovf   = period_ovf_q;
    assign stuck        = stuck_q;

endmodule

// File: tb/tb_clock_divider_monitor.sv
// Self-checking bench: a wide-period and a 4-bit-period monitor share stimulus
// and are compared every cycle against an arithmetic model of the measurement.
module tb_clock_divider_monitor;

    localparam int G      = 100;
    localparam int S      = 2;
    localparam int PMAX_W = 65535;
    localparam int PMAX_N = 15;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic enable = 1'b0;
    logic sig_in = 1'b0;

    logic [15:0] count_w, count_n, period_w;
    logic [3:0]  period_n;
    logic        cv_w, cv_n, pv_w, pv_n, ovf_w, ovf_n, stuck_w, stuck_n;

    always #5 clk = ~clk;

    clock_divider_monitor #(.GATE_CYCLES(G), .CNT_W(16), .PER_W(16), .SYNC_STAGES(S)) dut_w (
        .clk_in(clk), .nrst(nrst), .enable(enable), .sig_in(sig_in),
        .count_out(count_w), .count_valid(cv_w), .period_out(period_w),
        .period_valid(pv_w), .period_ovf(ovf_w), .stuck(stuck_w)
    );

    clock_divider_monitor #(.GATE_CYCLES(G), .CNT_W(16), .PER_W(4), .SYNC_STAGES(S)) dut_n (
        .clk_in(clk), .nrst(nrst), .enable(enable), .sig_in(sig_in),
        .count_out(count_n), .count_valid(cv_n), .period_out(period_n),
        .period_valid(pv_n), .period_ovf(ovf_n), .stuck(stuck_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cv_seen  = 0;
    int pv_seen  = 0;

    // Model: sig_in samples, window/period bookkeeping and expected outputs.
    bit hist[S+2];
    bit m_active, m_armed;
    int m_t, m_win, m_since;
    int e_count, e_per_w, e_per_n;
    bit e_cv, e_pv, e_ovf_w, e_ovf_n, e_stuck;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S + 2; i++) hist[i] = 1'b0;
        m_active = 0; m_armed = 0; m_t = 0; m_win = 0; m_since = 0;
        e_count = 0; e_per_w = 0; e_per_n = 0;
        e_cv = 0; e_pv = 0; e_ovf_w = 0; e_ovf_n = 0; e_stuck = 0;
    endtask

    // One clock edge of the specified behaviour: a sig_in rise sampled at edge j
    // is acted on at edge j+S.
    task automatic model_step();
        bit r;
        if (!nrst) begin
            model_reset();
            return;
        end
        for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sig_in;
        r = hist[S] && !hist[S+1];
        e_cv = 0;
        e_pv = 0;
        if (!enable) begin
            m_active = 0; m_armed = 0; m_win = 0;
        end else if (!m_active) begin
            m_active = 1; m_armed = 0; m_t = 0; m_win = 0;
        end else begin
            m_t++;
            if (r && m_win < 65535) m_win++;
            if (m_t % G == 0) begin
                e_count = m_win; e_cv = 1; e_stuck = (m_win == 0); m_win = 0;
            end
            if (r) begin
                if (m_armed) begin
                    e_pv    = 1;
                    e_per_w = (m_since > PMAX_W) ? PMAX_W : m_since;
                    e_ovf_w = (m_since >= PMAX_W);
                    e_per_n = (m_since > PMAX_N) ? PMAX_N : m_since;
                    e_ovf_n = (m_since >= PMAX_N);
                end
                m_armed = 1;
                m_since = 1;
            end else begin
                m_since++;
            end
        end
    endtask

    task automatic compare_all();
        check("count_out_w",    32'(count_w),  32'(e_count));
        check("count_out_n",    32'(count_n),  32'(e_count));
        check("count_valid_w",  32'(cv_w),     32'(e_cv));
        check("count_valid_n",  32'(cv_n),     32'(e_cv));
        check("period_out_w",   32'(period_w), 32'(e_per_w));
        check("period_out_n",   32'(period_n), 32'(e_per_n));
        check("period_valid_w", 32'(pv_w),     32'(e_pv));
        check("period_valid_n", 32'(pv_n),     32'(e_pv));
        check("period_ovf_w",   32'(ovf_w),    32'(e_ovf_w));
        check("period_ovf_n",   32'(ovf_n),    32'(e_ovf_n));
        check("stuck_w",        32'(stuck_w),  32'(e_stuck));
        check("stuck_n",        32'(stuck_n),  32'(e_stuck));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (cv_w) cv_seen++;
        if (pv_w) pv_seen++;
    endtask

    task automatic do_reset();
        nrst = 1'b0; enable = 1'b0; sig_in = 1'b0;
        cycle();
        nrst = 1'b1;
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        model_step();
        #2 nrst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        sig_in = 1'b0;
        cycle();
        nrst = 1'b1;
    endtask

    typedef struct {
        int half;
        int exp_count;
        bit exp_stuck;
        int exp_per_w;
        int exp_per_n;
        bit exp_ovf_n;
        bit exp_any_pv;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int found;
        int half, ph;
        model_reset();

        vecs[0] = '{half: 5,  exp_count: 10, exp_stuck: 0, exp_per_w: 10, exp_per_n: 10, exp_ovf_n: 0, exp_any_pv: 1};
        vecs[1] = '{half: 0,  exp_count: 0,  exp_stuck: 1, exp_per_w: 0,  exp_per_n: 0,  exp_ovf_n: 0, exp_any_pv: 0};
        vecs[2] = '{half: 2,  exp_count: 25, exp_stuck: 0, exp_per_w: 4,  exp_per_n: 4,  exp_ovf_n: 0, exp_any_pv: 1};
        vecs[3] = '{half: 10, exp_count: 5,  exp_stuck: 0, exp_per_w: 20, exp_per_n: 15, exp_ovf_n: 1, exp_any_pv: 1};
        vecs[4] = '{half: 25, exp_count: 2,  exp_stuck: 0, exp_per_w: 50, exp_per_n: 15, exp_ovf_n: 1, exp_any_pv: 1};

        // Steady periodic inputs over two full windows.
        foreach (vecs[v]) begin
            do_reset();
            enable = 1'b1;
            cv_seen = 0;
            pv_seen = 0;
            for (int c = 0; c < 205; c++) begin
                if (vecs[v].half > 0 && c > 0 && c % vecs[v].half == 0) sig_in = ~sig_in;
                cycle();
            end
            check("vec_count",   32'(count_w),  32'(vecs[v].exp_count));
            check("vec_stuck",   32'(stuck_w),  32'(vecs[v].exp_stuck));
            check("vec_per_w",   32'(period_w), 32'(vecs[v].exp_per_w));
            check("vec_per_n",   32'(period_n), 32'(vecs[v].exp_per_n));
            check("vec_ovf_n",   32'(ovf_n),    32'(vecs[v].exp_ovf_n));
            check("vec_windows", 32'(cv_seen),  32'd2);
            check("vec_any_pv",  32'(pv_seen > 0), 32'(vecs[v].exp_any_pv));
        end

        // Narrow period counter saturates, then recovers on a short period.
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 130; c++) begin
            if (c > 0 && c % 20 == 0) sig_in = ~sig_in;
            cycle();
        end
        check("sat_per_n", 32'(period_n), 32'd15);
        check("sat_ovf_n", 32'(ovf_n),    32'd1);
        for (int c = 0; c < 36; c++) begin
            if (c % 3 == 0) sig_in = ~sig_in;
            cycle();
        end
        check("rec_per_n", 32'(period_n), 32'd6);
        check("rec_ovf_n", 32'(ovf_n),    32'd0);
        check("rec_per_w", 32'(period_w), 32'd6);

        // Rise acted on in the terminal gate cycle, and one just after it.
        do_reset();
        enable = 1'b1;
        for (int c = 0; c <= 300; c++) begin
            if (c == 98)  sig_in = 1'b1;
            if (c == 150) sig_in = 1'b0;
            if (c == 199) sig_in = 1'b1;
            cycle();
            if (c == 100) begin
                check("term_cv",    32'(cv_w),    32'd1);
                check("term_count", 32'(count_w), 32'd1);
            end
            if (c == 200) begin
                check("late_count", 32'(count_w), 32'd0);
                check("late_stuck", 32'(stuck_w), 32'd1);
            end
            if (c == 300) begin
                check("next_count", 32'(count_w), 32'd1);
                check("next_stuck", 32'(stuck_w), 32'd0);
            end
        end

        // Enable dropped mid-window, then restored.
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 51; c++) begin
            if (c > 0 && c % 5 == 0) sig_in = ~sig_in;
            cycle();
        end
        enable = 1'b0;
        sig_in = 1'b0;
        cv_seen = 0;
        for (int c = 0; c < 10; c++) cycle();
        check("drop_no_cv", 32'(cv_seen), 32'd0);
        enable = 1'b1;
        pv_seen = 0;
        found = -1;
        for (int c = 0; c < 150 && found < 0; c++) begin
            if (c == 2) sig_in = 1'b1;
            cycle();
            if (c == 19) check("arm_no_pv", 32'(pv_seen), 32'd0);
            if (cv_w) found = c;
        end
        check("reenable_cv_at", 32'(found), 32'd100);

        // Asynchronous reset mid-window, then a clean restart.
        do_reset();
        enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (c > 0 && c % 5 == 0) sig_in = ~sig_in;
            cycle();
        end
        async_reset();
        for (int c = 0; c <= 100; c++) begin
            if (c > 0 && c % 5 == 0) sig_in = ~sig_in;
            cycle();
        end
        check("post_rst_cv",    32'(cv_w),    32'd1);
        check("post_rst_count", 32'(count_w), 32'd10);

        // Randomised stimulus against the model.
        do_reset();
        enable = 1'b1;
        half = 5;
        ph = 5;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 249) == 0) enable = ~enable;
            if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            if ($urandom_range(0, 39) == 0)
                half = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            if (ph <= 0) begin
                if (half > 0) sig_in = ~sig_in;
                ph = (half > 0) ? half : 50;
            end
            ph--;
            if (c == 1700) async_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
